// File: rtl/fpu_pkg.sv
// Shared FPU types: floating-point format selector, IEEE exception flag bundle,
// and the format-to-width helper used to size result datapaths.
package fpu_pkg;

  typedef enum logic [1:0] {
    FP32 = 2'd0,
    FP64 = 2'd1,
    FP16 = 2'd2,
    BF16 = 2'd3
  } fp_format_e;

  // Bit order matches the fflags CSR: NV is the MSB, NX the LSB.
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  function automatic int flen_bits(fp_format_e fmt);
    case (fmt)
      FP64:       return 64;
      FP16, BF16: return 16;
      default:    return 32;
    endcase
  endfunction

endpackage

// File: rtl/fpu_utils_rr_arb.sv
// Combinational round-robin arbiter: the first requester at or after ptr
// (wrapping) wins. Reusable by FPU issue and writeback logic.
module fpu_utils_rr_arb #(
  parameter  int N     = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      cand = IDX_W'((int'(ptr) + i) % N);
      if (!grant_vld && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        grant_vld   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpu_wb_arb.sv
// FPU writeback arbiter: round-robin collection of execution-unit results into
// a 2-entry registered writeback channel, plus the sticky accrued fflags.
module fpu_wb_arb
  import fpu_pkg::*;
#(
  parameter  fp_format_e FP_FMT    = FP32,
  parameter  int         UNIT_NUM  = 4,
  parameter  int         TAG_WIDTH = 5,
  localparam int         FLEN      = flen_bits(FP_FMT),
  localparam int         UNIT_W    = $clog2(UNIT_NUM)
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic [UNIT_NUM-1:0]                i_unit_valid,
  output logic [UNIT_NUM-1:0]                o_unit_ready,
  input  logic [UNIT_NUM-1:0][FLEN-1:0]      i_unit_result,
  input  fflags_t [UNIT_NUM-1:0]             i_unit_fflags,
  input  logic [UNIT_NUM-1:0][TAG_WIDTH-1:0] i_unit_tag,
  output logic                               o_wb_valid,
  input  logic                               i_wb_ready,
  output logic [FLEN-1:0]                    o_wb_result,
  output fflags_t                            o_wb_fflags,
  output logic [TAG_WIDTH-1:0]               o_wb_tag,
  output logic [UNIT_W-1:0]                  o_wb_unit,
  input  logic                               i_fflags_clr,
  output fflags_t                            o_fflags_acc
);

  typedef struct packed {
    logic [FLEN-1:0]      result;
    fflags_t              fflags;
    logic [TAG_WIDTH-1:0] tag;
    logic [UNIT_W-1:0]    unit;
  } wb_entry_t;

  wb_entry_t         mem_p0 [2];
  logic [1:0]        count_p0;
  logic              rd_ptr_p0;
  logic              wr_ptr_p0;
  logic [UNIT_W-1:0] rr_ptr_p0;
  fflags_t           fflags_acc_p0;

  logic [UNIT_NUM-1:0] grant;
  logic [UNIT_W-1:0]   grant_idx;
  logic                grant_vld;
  logic                has_space;
  logic                push;
  logic                pop;
  wb_entry_t           push_entry;
  wb_entry_t           head;
  logic [1:0]          count_nxt;
  logic [UNIT_W-1:0]   rr_ptr_nxt;
  fflags_t             fflags_acc_nxt;

  fpu_utils_rr_arb #(
    .N (UNIT_NUM)
  ) u_rr_arb (
    .req       (i_unit_valid),
    .ptr       (rr_ptr_p0),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  // Stage 0: grant and accept. Readiness depends only on registered occupancy,
  // so the sink's ready never reaches the upstream units combinationally.
  assign has_space    = (count_p0 != 2'd2);
  assign o_unit_ready = (i_rst_n && has_space) ? grant : '0;
  assign push         = grant_vld && has_space;
  assign pop          = o_wb_valid && i_wb_ready;

  always_comb begin
    push_entry        = '0;
    push_entry.result = i_unit_result[grant_idx];
    push_entry.fflags = i_unit_fflags[grant_idx];
    push_entry.tag    = i_unit_tag[grant_idx];
    push_entry.unit   = grant_idx;
  end

  assign rr_ptr_nxt = (grant_idx == UNIT_W'(UNIT_NUM - 1)) ? '0 : grant_idx + 1'b1;

  always_comb begin
    count_nxt = count_p0;
    case ({push, pop})
      2'b10:   count_nxt = count_p0 + 2'd1;
      2'b01:   count_nxt = count_p0 - 2'd1;
      default: count_nxt = count_p0;
    endcase
  end

  // A flag retiring in the same cycle as a CSR clear survives the clear.
  always_comb begin
    fflags_acc_nxt = i_fflags_clr ? '0 : fflags_acc_p0;
    if (pop) begin
      fflags_acc_nxt = fflags_t'(fflags_acc_nxt | head.fflags);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_p0      <= '0;
      rd_ptr_p0     <= 1'b0;
      wr_ptr_p0     <= 1'b0;
      rr_ptr_p0     <= '0;
      fflags_acc_p0 <= '0;
    end else begin
      count_p0      <= count_nxt;
      fflags_acc_p0 <= fflags_acc_nxt;
      if (push) begin
        wr_ptr_p0 <= ~wr_ptr_p0;
        rr_ptr_p0 <= rr_ptr_nxt;
      end
      if (pop) begin
        rd_ptr_p0 <= ~rd_ptr_p0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_p0[wr_ptr_p0] <= push_entry;
    end
  end

  // Stage 1: buffered head drives the writeback channel; payload is zeroed
  // whenever nothing is buffered, which also covers reset.
  assign head         = mem_p0[rd_ptr_p0];
  assign o_wb_valid   = (count_p0 != 2'd0);
  assign o_wb_result  = o_wb_valid ? head.result : '0;
  assign o_wb_fflags  = o_wb_valid ? head.fflags : '0;
  assign o_wb_tag     = o_wb_valid ? head.tag    : '0;
  assign o_wb_unit    = o_wb_valid ? head.unit   : '0;
  assign o_fflags_acc = fflags_acc_p0;

endmodule

// File: tb/tb_fpu_wb_arb.sv
// Directed bench for fpu_wb_arb with a queue-based reference model checked
// every cycle and literal expectations for each scenario.
module tb_fpu_wb_arb;
  import fpu_pkg::*;

  localparam int N  = 4;
  localparam int TW = 5;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [N-1:0]         u_valid;
  logic [N-1:0]         u_ready;
  logic [N-1:0][31:0]   u_res;
  fflags_t [N-1:0]      u_ff;
  logic [N-1:0][TW-1:0] u_tag;
  logic                 wb_valid;
  logic                 wb_ready;
  logic [31:0]          wb_res;
  fflags_t              wb_ff;
  logic [TW-1:0]        wb_tag;
  logic [1:0]           wb_unit;
  logic                 clr;
  fflags_t              acc;

  always #5 clk = ~clk;

  fpu_wb_arb #(
    .FP_FMT    (FP32),
    .UNIT_NUM  (N),
    .TAG_WIDTH (TW)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_unit_valid  (u_valid),
    .o_unit_ready  (u_ready),
    .i_unit_result (u_res),
    .i_unit_fflags (u_ff),
    .i_unit_tag    (u_tag),
    .o_wb_valid    (wb_valid),
    .i_wb_ready    (wb_ready),
    .o_wb_result   (wb_res),
    .o_wb_fflags   (wb_ff),
    .o_wb_tag      (wb_tag),
    .o_wb_unit     (wb_unit),
    .i_fflags_clr  (clr),
    .o_fflags_acc  (acc)
  );

  typedef struct packed {
    logic [31:0]   res;
    logic [4:0]    ff;
    logic [TW-1:0] tag;
  } src_t;

  typedef struct packed {
    logic [31:0]   res;
    logic [4:0]    ff;
    logic [TW-1:0] tag;
    logic [1:0]    unit;
  } wb_t;

  src_t       src_q [N][$];
  wb_t        m_q[$];
  int         pop_log[$];
  int         m_ptr = 0;
  logic [4:0] m_acc = '0;
  logic [N-1:0] hs_seen = '0;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: a plain queue of pending writebacks and an integer pointer.
  always @(negedge clk) begin
    logic [1:0]   gi;
    logic         found;
    logic [N-1:0] er;
    logic         push, pop;
    logic [4:0]   nacc;
    wb_t          e;
    if (!rst_n) begin
      chk("rst_wb_valid", 64'(wb_valid), 64'(0));
      chk("rst_wb_result", 64'(wb_res), 64'(0));
      chk("rst_wb_fflags", 64'(wb_ff), 64'(0));
      chk("rst_wb_tag", 64'(wb_tag), 64'(0));
      chk("rst_wb_unit", 64'(wb_unit), 64'(0));
      chk("rst_acc", 64'(acc), 64'(0));
      chk("rst_ready", 64'(u_ready), 64'(0));
      m_q.delete();
      m_ptr   = 0;
      m_acc   = '0;
      hs_seen = '0;
    end else begin
      hs_seen = u_valid & u_ready;
      chk("wb_valid", 64'(wb_valid), 64'(m_q.size() != 0));
      if (m_q.size() != 0) begin
        chk("wb_result", 64'(wb_res), 64'(m_q[0].res));
        chk("wb_fflags", 64'(wb_ff), 64'(m_q[0].ff));
        chk("wb_tag", 64'(wb_tag), 64'(m_q[0].tag));
        chk("wb_unit", 64'(wb_unit), 64'(m_q[0].unit));
      end
      chk("fflags_acc", 64'(acc), 64'(m_acc));
      found = 1'b0;
      gi    = '0;
      for (int i = 0; i < N; i++) begin
        logic [1:0] c;
        c = 2'((m_ptr + i) % N);
        if (!found && u_valid[c]) begin
          found = 1'b1;
          gi    = c;
        end
      end
      er = '0;
      if (found && m_q.size() < 2) er[gi] = 1'b1;
      chk("unit_ready", 64'(u_ready), 64'(er));
      push = (er != '0);
      pop  = (m_q.size() != 0) && wb_ready;
      nacc = clr ? 5'b0 : m_acc;
      if (pop) begin
        nacc = nacc | m_q[0].ff;
        pop_log.push_back(int'(m_q[0].unit));
        void'(m_q.pop_front());
      end
      if (push) begin
        e.res  = u_res[gi];
        e.ff   = u_ff[gi];
        e.tag  = u_tag[gi];
        e.unit = gi;
        m_q.push_back(e);
        m_ptr = (int'(gi) + 1) % N;
      end
      m_acc = nacc;
    end
  end

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      if (src_q[k].size() != 0) begin
        u_valid[k] = 1'b1;
        u_res[k]   = src_q[k][0].res;
        u_ff[k]    = src_q[k][0].ff;
        u_tag[k]   = src_q[k][0].tag;
      end else begin
        u_valid[k] = 1'b0;
        u_res[k]   = '0;
        u_ff[k]    = '0;
        u_tag[k]   = '0;
      end
    end
  endtask

  // Advance one clock; returns 3 time units after the rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (hs_seen[k] && src_q[k].size() != 0) void'(src_q[k].pop_front());
    end
    drive();
    #2;
  endtask

  task automatic flush_src();
    for (int k = 0; k < N; k++) src_q[k].delete();
    drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush_src();
    repeat (2) cycle();
    rst_n = 1'b1;
  endtask

  task automatic add_src(input int k, input logic [31:0] r, input logic [4:0] f,
                         input logic [TW-1:0] t);
    src_t s;
    s.res = r;
    s.ff  = f;
    s.tag = t;
    src_q[k].push_back(s);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int base;
    int exp3 [4];
    exp3 = '{1, 2, 1, 2};
    wb_ready = 1'b1;
    clr      = 1'b0;
    u_valid  = '0;
    u_res    = '0;
    u_ff     = '0;
    u_tag    = '0;

    do_reset();
    chk("t0_wb_valid", 64'(wb_valid), 64'(0));
    chk("t0_acc", 64'(acc), 64'(0));

    // Single unit 0, one result with NX.
    add_src(0, 32'h3F80_0000, 5'b00001, 5'd3);
    drive();
    cycle();
    chk("t1_valid", 64'(wb_valid), 64'(1));
    chk("t1_result", 64'(wb_res), 64'h3F80_0000);
    chk("t1_tag", 64'(wb_tag), 64'(3));
    chk("t1_unit", 64'(wb_unit), 64'(0));
    cycle();
    chk("t1_acc", 64'(acc), 64'(5'b00001));
    chk("t1_drained", 64'(wb_valid), 64'(0));

    // All four units requesting continuously.
    do_reset();
    for (int k = 0; k < N; k++)
      for (int j = 0; j < 3; j++)
        add_src(k, 32'h4000_0000 + 32'(k * 16 + j), 5'b0, TW'(k * 4 + j));
    drive();
    base = pop_log.size();
    repeat (6) cycle();
    chk("t2_streaming", 64'(wb_valid), 64'(1));
    repeat (10) cycle();
    chk("t2_count", 64'(pop_log.size() - base), 64'(12));
    if (pop_log.size() - base == 12)
      for (int i = 0; i < 12; i++) chk("t2_order", 64'(pop_log[base + i]), 64'(i % 4));

    // Backpressure with units 1 and 2.
    do_reset();
    wb_ready = 1'b0;
    add_src(1, 32'h1111_0001, 5'b0, 5'd1);
    add_src(1, 32'h1111_0002, 5'b0, 5'd2);
    add_src(2, 32'h2222_0001, 5'b0, 5'd5);
    add_src(2, 32'h2222_0002, 5'b0, 5'd6);
    drive();
    repeat (5) cycle();
    chk("t3_ready_blocked", 64'(u_ready), 64'(0));
    chk("t3_head_unit", 64'(wb_unit), 64'(1));
    wb_ready = 1'b1;
    base = pop_log.size();
    repeat (8) cycle();
    chk("t3_count", 64'(pop_log.size() - base), 64'(4));
    if (pop_log.size() - base == 4)
      for (int i = 0; i < 4; i++) chk("t3_order", 64'(pop_log[base + i]), 64'(exp3[i]));

    // NV then DZ retiring, clear coincident with DZ's pop.
    do_reset();
    add_src(0, 32'h7FC0_0000, 5'b10000, 5'd7);
    add_src(0, 32'h7F80_0000, 5'b01000, 5'd8);
    drive();
    cycle();
    cycle();
    chk("t4_acc_nv", 64'(acc), 64'(5'b10000));
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    chk("t4_acc_dz", 64'(acc), 64'(5'b01000));

    // Asynchronous reset with two entries buffered.
    wb_ready = 1'b0;
    add_src(1, 32'hAAAA_0001, 5'b00100, 5'd9);
    add_src(2, 32'hBBBB_0002, 5'b00010, 5'd10);
    drive();
    repeat (3) cycle();
    chk("t6_buffered", 64'(wb_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(wb_valid), 64'(0));
    chk("t6_rst_acc", 64'(acc), 64'(0));
    chk("t6_rst_ready", 64'(u_ready), 64'(0));
    flush_src();
    cycle();
    cycle();
    rst_n    = 1'b1;
    wb_ready = 1'b1;
    add_src(0, 32'hC0DE_0000, 5'b0, 5'd11);
    add_src(3, 32'hC0DE_0003, 5'b0, 5'd12);
    drive();
    cycle();
    chk("t6_after_valid", 64'(wb_valid), 64'(1));
    chk("t6_after_unit", 64'(wb_unit), 64'(0));
    repeat (4) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
